// File: rtl/mux_byte_serializer_pkg.sv
// Shared widths, state encoding and bit-order helpers for the byte serializer.
package mux_byte_serializer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEL_W  = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } state_e;

    function automatic logic [SEL_W-1:0] first_idx(input bit msb_first);
        return msb_first ? SEL_W'(BYTE_W - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] last_idx(input bit msb_first);
        return msb_first ? '0 : SEL_W'(BYTE_W - 1);
    endfunction

endpackage

// File: rtl/mux_byte_serializer_if.sv
// Byte-in / bit-out handshake bundle; slave is the serializer, master the surrounding logic.
interface mux_byte_serializer_if;
    import mux_byte_serializer_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              serial_out;
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic              done;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, serial_out, out_valid, sel, busy, done
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, serial_out, out_valid, sel, busy, done
    );

endinterface

// File: rtl/bit_select_8to1.sv
// Purely combinational 8:1 bit select.
module bit_select_8to1
    import mux_byte_serializer_pkg::*;
(
    input  logic [BYTE_W-1:0] in_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic              y_o
);

    assign y_o = in_i[sel_i];

endmodule

// File: rtl/mux_byte_serializer.sv
// Parallel-to-serial stage: latches a byte, sweeps the select index and streams one bit per
// accepted transfer.
module mux_byte_serializer
    import mux_byte_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    mux_byte_serializer_if.slave  bus
);

    localparam logic [SEL_W-1:0] First = first_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] Last  = last_idx(MSB_FIRST);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic shifting, xfer, at_last, in_ready, load, sel_bit;

    always_comb begin
        shifting = (state_q == StShift);
        xfer     = shifting & bus.out_ready;
        at_last  = (cnt_q == Last);
        // Ready during the last-bit transfer lets the next byte follow with no bubble.
        in_ready = ~rst & (~shifting | (xfer & at_last));
        load     = bus.in_valid & in_ready;

        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = xfer & at_last;

        if (load) begin
            data_d  = bus.in_data;
            cnt_d   = First;
            state_d = StShift;
        end else if (xfer) begin
            if (at_last) begin
                state_d = StIdle;
            end else begin
                cnt_d = MSB_FIRST ? cnt_q - SEL_W'(1) : cnt_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= First;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    bit_select_8to1 u_bit_select (
        .in_i  (data_q),
        .sel_i (cnt_q),
        .y_o   (sel_bit)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = shifting;
    assign bus.busy       = shifting;
    assign bus.sel        = cnt_q;
    assign bus.serial_out = shifting & sel_bit;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_byte_serializer.sv
// Directed bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_mux_byte_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] in_data = 8'hC5;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_byte_serializer_if bus0 ();
    mux_byte_serializer_if bus1 ();

    assign bus0.in_data   = in_data;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    mux_byte_serializer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mux_byte_serializer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       e_ov;
        logic       e_rdy;
        logic       e_done;
        logic [2:0] e_sel0;
        logic       e_ser0;
        logic [2:0] e_sel1;
        logic       e_ser1;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic r, iv, input logic [7:0] d, input logic ordy,
                                input logic ov, rdy, dn, input logic [2:0] s0, input logic b0,
                                input logic [2:0] s1, input logic b1);
        vec_t v;
        v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy;
        v.e_ov = ov; v.e_rdy = rdy; v.e_done = dn;
        v.e_sel0 = s0; v.e_ser0 = b0; v.e_sel1 = s1; v.e_ser1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    int         stall_sel[11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
    logic       stall_rdy[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [7:0] c5 = 8'hC5;
    logic [15:0] pair = 16'h0FC5;

    initial begin
        // rst, iv, din, ordy | ov, rdy, done, sel0, ser0, sel1, ser1
        tbl[0]  = mk(1, 1, 8'hC5, 1, 0, 0, 0, 3'd0, 0, 3'd7, 0);
        tbl[1]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 3'd7, 0);
        tbl[2]  = mk(0, 1, 8'hC5, 1, 0, 1, 0, 3'd0, 0, 3'd7, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd0, 1, 3'd7, 1);
        tbl[4]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd1, 0, 3'd6, 1);
        tbl[5]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd2, 1, 3'd5, 0);
        tbl[6]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd3, 0, 3'd4, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd4, 0, 3'd3, 0);
        tbl[8]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd5, 0, 3'd2, 1);
        tbl[9]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 3'd6, 1, 3'd1, 0);
        tbl[10] = mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd7, 1, 3'd0, 1);
        tbl[11] = mk(0, 0, 8'h00, 1, 0, 1, 1, 3'd7, 0, 3'd0, 0);
        tbl[12] = mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd7, 0, 3'd0, 0);

        // Reset, then one byte through both bit orders.
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst, tbl[i].iv, tbl[i].din, tbl[i].ordy);
            chk($sformatf("row%0d out_valid", i), bus0.out_valid, tbl[i].e_ov);
            chk($sformatf("row%0d busy", i), bus0.busy, tbl[i].e_ov);
            chk($sformatf("row%0d in_ready", i), bus0.in_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d done", i), bus0.done, tbl[i].e_done);
            chk($sformatf("row%0d sel", i), bus0.sel, tbl[i].e_sel0);
            chk($sformatf("row%0d serial_out", i), bus0.serial_out, tbl[i].e_ser0);
            chk($sformatf("row%0d msb out_valid", i), bus1.out_valid, tbl[i].e_ov);
            chk($sformatf("row%0d msb in_ready", i), bus1.in_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d msb done", i), bus1.done, tbl[i].e_done);
            chk($sformatf("row%0d msb sel", i), bus1.sel, tbl[i].e_sel1);
            chk($sformatf("row%0d msb serial_out", i), bus1.serial_out, tbl[i].e_ser1);
        end

        // Downstream stall for three cycles at sel=3.
        cyc(0, 1, 8'hC5, 1);
        chk("stall load in_ready", bus0.in_ready, 1);
        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, 8'h00, stall_rdy[i]);
            chk($sformatf("stall%0d out_valid", i), bus0.out_valid, 1);
            chk($sformatf("stall%0d sel", i), bus0.sel, 8'(stall_sel[i]));
            chk($sformatf("stall%0d serial_out", i), bus0.serial_out, c5[stall_sel[i]]);
            chk($sformatf("stall%0d done", i), bus0.done, 0);
        end
        cyc(0, 0, 8'h00, 1);
        chk("stall done", bus0.done, 1);
        chk("stall idle out_valid", bus0.out_valid, 0);

        // Back-to-back bytes with in_valid held.
        cyc(0, 1, 8'hC5, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, (i < 15) ? 1'b1 : 1'b0, 8'h0F, 1);
            chk($sformatf("b2b%0d out_valid", i), bus0.out_valid, 1);
            chk($sformatf("b2b%0d sel", i), bus0.sel, 8'(i % 8));
            chk($sformatf("b2b%0d serial_out", i), bus0.serial_out, pair[i]);
            chk($sformatf("b2b%0d in_ready", i), bus0.in_ready, (i == 7 || i == 15) ? 1 : 0);
            chk($sformatf("b2b%0d done", i), bus0.done, (i == 8) ? 1 : 0);
        end
        cyc(0, 0, 8'h00, 1);
        chk("b2b final done", bus0.done, 1);
        chk("b2b final out_valid", bus0.out_valid, 0);

        // Reset in the middle of a byte, then a fresh byte.
        cyc(0, 1, 8'hFF, 1);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 4) ? 1'b1 : 1'b0, 0, 8'h00, 1);
            chk($sformatf("rst%0d sel", i), bus0.sel, 8'(i));
            chk($sformatf("rst%0d serial_out", i), bus0.serial_out, 1);
            chk($sformatf("rst%0d in_ready", i), bus0.in_ready, 0);
        end
        cyc(0, 0, 8'h00, 1);
        chk("post-rst out_valid", bus0.out_valid, 0);
        chk("post-rst busy", bus0.busy, 0);
        chk("post-rst done", bus0.done, 0);
        chk("post-rst sel", bus0.sel, 0);
        chk("post-rst in_ready", bus0.in_ready, 1);
        cyc(0, 1, 8'h01, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 8'h00, 1);
            chk($sformatf("one%0d out_valid", i), bus0.out_valid, 1);
            chk($sformatf("one%0d sel", i), bus0.sel, 8'(i));
            chk($sformatf("one%0d serial_out", i), bus0.serial_out, (i == 0) ? 1 : 0);
        end
        cyc(0, 0, 8'h00, 1);
        chk("one done", bus0.done, 1);
        chk("one idle out_valid", bus0.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
